// File: rtl/div_pkg.sv
// Shared constants, state encoding and reciprocal seed table for the
// Q5.10 Newton-Raphson divider front end.
package div_pkg;

    localparam int FRAC_BITS = 10;
    localparam int W         = 16;
    localparam logic [W-1:0] SEED_MAX = 16'h7FFF;

    // Controller states of the seed generator.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ABS  = 3'd1,
        ST_NORM = 3'd2,
        ST_SEED = 3'd3,
        ST_LOAD = 3'd4,
        ST_WAIT = 3'd5
    } state_t;

    // round(1024 / (1 + (k + 0.5) / 8)) for k = 0..7; entry k sits at index k.
    localparam logic [7:0][9:0] SEED_LUT = {
        10'd529, 10'd565, 10'd607, 10'd655,
        10'd712, 10'd780, 10'd862, 10'd964
    };

    // Absolute value of a signed 16-bit word as a 15-bit magnitude; the single
    // unrepresentable case (-32768) saturates to the largest magnitude.
    function automatic logic [14:0] abs_sat(input logic [15:0] v);
        logic [15:0] neg;
        neg = 16'd0 - v;
        if (v == 16'h8000) begin
            abs_sat = 15'h7FFF;
        end else if (v[15]) begin
            abs_sat = neg[14:0];
        end else begin
            abs_sat = v[14:0];
        end
    endfunction

endpackage

// File: rtl/recip_seed_gen_if.sv
// Operand handshake and divider-load bundle of the reciprocal seed generator.
interface recip_seed_gen_if;
    import div_pkg::*;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_nr;
    logic [W-1:0] in_dr;
    logic         load;
    logic [W-1:0] nr;
    logic [W-1:0] dr;
    logic [W-1:0] initial_guess;
    logic         div_by_zero;
    logic         busy;

    // Operand producer / divider side.
    modport master (
        output in_valid, in_nr, in_dr,
        input  in_ready, load, nr, dr, initial_guess, div_by_zero, busy
    );

    // Seed generator side.
    modport slave (
        input  in_valid, in_nr, in_dr,
        output in_ready, load, nr, dr, initial_guess, div_by_zero, busy
    );

endinterface

// File: rtl/recip_seed_lut.sv
// Combinational mantissa lookup: three bits below the normalised leading one
// select a 10-bit reciprocal fraction.
module recip_seed_lut
    import div_pkg::*;
(
    input  logic [2:0] k,
    output logic [9:0] f
);

    // Table read from the shared package constant.
    always_comb begin
        f = SEED_LUT[k];
    end

endmodule

// File: rtl/recip_seed_gen.sv
// Reciprocal seed front end: captures a Q5.10 operand pair, normalises |dr|
// one bit per cycle, scales a table fraction back by the shift count, pulses
// load to the divider and then stays busy while the divider iterates.
module recip_seed_gen
    import div_pkg::*;
#(
    parameter int HOLD_CYCLES = 102
) (
    input  logic             clk,
    input  logic             rst,
    recip_seed_gen_if.slave  bus
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);

    state_t         state_r, state_s;
    logic [14:0]    mag_r, mag_s;
    logic [3:0]     cnt_r, cnt_s;
    logic           sign_r, sign_s;
    logic [HW-1:0]  hold_r, hold_s;
    logic [W-1:0]   nr_r, nr_s;
    logic [W-1:0]   dr_r, dr_s;
    logic [W-1:0]   guess_r, guess_s;
    logic           dbz_r, dbz_s;
    logic           load_r, load_s;
    logic           ready_r, ready_s;
    logic           busy_r, busy_s;

    logic [14:0]    abs_s;
    logic [9:0]     lut_f_s;
    logic [25:0]    scaled_s;
    logic [14:0]    seed_mag_s;
    logic [W-1:0]   seed_signed_s;

    recip_seed_lut u_lut (
        .k (mag_r[13:11]),
        .f (lut_f_s)
    );

    // Scale the table fraction by 2^(cnt-4), saturating large seeds.
    always_comb begin
        scaled_s   = 26'd0;
        seed_mag_s = 15'd0;
        if (cnt_r >= 4'd4) begin
            scaled_s = {16'd0, lut_f_s} << (cnt_r - 4'd4);
            if (scaled_s > 26'd32767) begin
                seed_mag_s = 15'h7FFF;
            end else begin
                seed_mag_s = scaled_s[14:0];
            end
        end else begin
            seed_mag_s = {5'd0, lut_f_s} >> (4'd4 - cnt_r);
        end
        if (sign_r) begin
            seed_signed_s = 16'd0 - {1'b0, seed_mag_s};
        end else begin
            seed_signed_s = {1'b0, seed_mag_s};
        end
    end

    // Next-state and next-datapath decode for the controller.
    always_comb begin
        state_s = state_r;
        mag_s   = mag_r;
        cnt_s   = cnt_r;
        sign_s  = sign_r;
        hold_s  = hold_r;
        nr_s    = nr_r;
        dr_s    = dr_r;
        guess_s = guess_r;
        dbz_s   = dbz_r;
        abs_s   = abs_sat(dr_r);

        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    nr_s    = bus.in_nr;
                    dr_s    = bus.in_dr;
                    state_s = ST_ABS;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ABS: begin
                sign_s = dr_r[15];
                mag_s  = abs_s;
                cnt_s  = 4'd0;
                if (abs_s == 15'd0) begin
                    dbz_s   = 1'b1;
                    guess_s = SEED_MAX;
                    state_s = ST_LOAD;
                end else begin
                    dbz_s   = 1'b0;
                    state_s = ST_NORM;
                end
            end
            ST_NORM: begin
                // A nonzero magnitude reaches bit 14 after at most 14 shifts.
                if (mag_r[14]) begin
                    state_s = ST_SEED;
                end else begin
                    mag_s = {mag_r[13:0], 1'b0};
                    cnt_s = cnt_r + 4'd1;
                end
            end
            ST_SEED: begin
                guess_s = seed_signed_s;
                state_s = ST_LOAD;
            end
            ST_LOAD: begin
                hold_s  = HW'(HOLD_CYCLES);
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (hold_r <= HW'(1)) begin
                    state_s = ST_IDLE;
                end else begin
                    hold_s = hold_r - HW'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Outputs are registered from the upcoming state so they line up with it.
        load_s  = (state_s == ST_LOAD);
        ready_s = (state_s == ST_IDLE);
        busy_s  = (state_s != ST_IDLE);
    end

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and registered outputs; reset clears everything except in_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            mag_r   <= 15'd0;
            cnt_r   <= 4'd0;
            sign_r  <= 1'b0;
            hold_r  <= '0;
            nr_r    <= 16'd0;
            dr_r    <= 16'd0;
            guess_r <= 16'd0;
            dbz_r   <= 1'b0;
            load_r  <= 1'b0;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            mag_r   <= mag_s;
            cnt_r   <= cnt_s;
            sign_r  <= sign_s;
            hold_r  <= hold_s;
            nr_r    <= nr_s;
            dr_r    <= dr_s;
            guess_r <= guess_s;
            dbz_r   <= dbz_s;
            load_r  <= load_s;
            ready_r <= ready_s;
            busy_r  <= busy_s;
        end
    end

    assign bus.in_ready      = ready_r;
    assign bus.load          = load_r;
    assign bus.nr            = nr_r;
    assign bus.dr            = dr_r;
    assign bus.initial_guess = guess_r;
    assign bus.div_by_zero   = dbz_r;
    assign bus.busy          = busy_r;

endmodule

// File: tb/tb_recip_seed_gen.sv
// Directed bench for recip_seed_gen. Cycle numbers count from the handshake
// edge: the first clock period after that edge is cycle 1.
module tb_recip_seed_gen;

    localparam int HOLD = 102;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    recip_seed_gen_if bus_if ();

    recip_seed_gen #(.HOLD_CYCLES(HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction: handshake, then watch load and in_ready each cycle.
    task automatic do_txn(input string tag, input logic [15:0] n, input logic [15:0] d,
                          input int exp_cyc, input logic [15:0] exp_guess, input logic exp_dbz);
        int load_at, load_cnt, ready_at;
        logic [15:0] g_at, nr_at, dr_at;
        logic dbz_at, busy_at;
        load_at = -1; ready_at = -1; load_cnt = 0;
        g_at = 16'd0; nr_at = 16'd0; dr_at = 16'd0; dbz_at = 1'b0; busy_at = 1'b0;
        @(negedge clk);
        check({tag, "_ready_before"}, 32'(bus_if.in_ready), 32'd1);
        bus_if.in_valid = 1'b1;
        bus_if.in_nr    = n;
        bus_if.in_dr    = d;
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            if (c > 1) @(negedge clk);
            if (bus_if.load) begin
                load_cnt++;
                if (load_at < 0) begin
                    load_at = c;
                    g_at    = bus_if.initial_guess;
                    nr_at   = bus_if.nr;
                    dr_at   = bus_if.dr;
                    dbz_at  = bus_if.div_by_zero;
                    busy_at = bus_if.busy;
                end
            end
            if (bus_if.in_ready) begin
                ready_at = c;
                break;
            end
        end
        check({tag, "_load_cycle"}, 32'(load_at), 32'(exp_cyc));
        check({tag, "_load_count"}, 32'(load_cnt), 32'd1);
        check({tag, "_guess"}, {16'd0, g_at}, {16'd0, exp_guess});
        check({tag, "_dbz"}, 32'(dbz_at), 32'(exp_dbz));
        check({tag, "_nr"}, {16'd0, nr_at}, {16'd0, n});
        check({tag, "_dr"}, {16'd0, dr_at}, {16'd0, d});
        check({tag, "_busy_at_load"}, 32'(busy_at), 32'd1);
        check({tag, "_ready_cycle"}, 32'(ready_at), 32'(exp_cyc + HOLD + 1));
        check({tag, "_guess_held"}, {16'd0, bus_if.initial_guess}, {16'd0, exp_guess});
        check({tag, "_busy_idle"}, 32'(bus_if.busy), 32'd0);
    endtask

    initial begin
        int load_cnt;
        int first_at, second_at;
        logic [15:0] first_dr, second_guess;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus_if.in_valid = 1'b0;
        bus_if.in_nr    = 16'd0;
        bus_if.in_dr    = 16'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state.
        check("rst_in_ready", 32'(bus_if.in_ready), 32'd1);
        check("rst_load", 32'(bus_if.load), 32'd0);
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        check("rst_nr", {16'd0, bus_if.nr}, 32'd0);
        check("rst_dr", {16'd0, bus_if.dr}, 32'd0);
        check("rst_guess", {16'd0, bus_if.initial_guess}, 32'd0);
        check("rst_dbz", 32'(bus_if.div_by_zero), 32'd0);

        // dr = 1.0: p=10, cnt=4, k=0 -> 964.
        do_txn("dr_1p0", 16'd3072, 16'd1024, 8, 16'd964, 1'b0);
        // dr = 0: straight to LOAD.
        do_txn("dr_zero", 16'd3072, 16'd0, 2, 16'h7FFF, 1'b1);
        // dr = 2.0: cnt=3 -> 964>>1.
        do_txn("dr_2p0", 16'd1024, 16'd2048, 7, 16'd482, 1'b0);
        // dr = -1.5: mag 0x600 normalises to 0x6000, k=4 -> -655.
        do_txn("dr_m1p5", 16'd1024, 16'hFA00, 8, 16'hFD71, 1'b0);
        // dr = 1 LSB: cnt=14, 964<<10 saturates.
        do_txn("dr_lsb", 16'd1024, 16'd1, 18, 16'h7FFF, 1'b0);
        // dr = -32768: magnitude saturates to 0x7FFF (k=7, f=529), 529>>4 = 33 -> -33.
        do_txn("dr_min", 16'd1024, 16'h8000, 4, 16'hFFDF, 1'b0);
        // dr = 0x7FFF: p=14, k=7 -> 33.
        do_txn("dr_max", 16'd1024, 16'h7FFF, 4, 16'd33, 1'b0);
        // dr = 4.0: cnt=2 -> 964>>2 = 241.
        do_txn("dr_4p0", 16'd1024, 16'h1000, 6, 16'd241, 1'b0);

        // Reset wins over a simultaneous handshake.
        @(negedge clk);
        rst = 1'b1;
        bus_if.in_valid = 1'b1;
        bus_if.in_nr    = 16'd3072;
        bus_if.in_dr    = 16'd1024;
        @(negedge clk);
        rst = 1'b0;
        bus_if.in_valid = 1'b0;
        check("rstpri_nr", {16'd0, bus_if.nr}, 32'd0);
        check("rstpri_dr", {16'd0, bus_if.dr}, 32'd0);
        check("rstpri_ready", 32'(bus_if.in_ready), 32'd1);
        @(negedge clk);
        check("rstpri_busy", 32'(bus_if.busy), 32'd0);

        // Reset in cycle 5 of a dr=1 transaction cancels the pending load.
        load_cnt = 0;
        bus_if.in_valid = 1'b1;
        bus_if.in_nr    = 16'd5;
        bus_if.in_dr    = 16'd1;
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) @(negedge clk);
            if (bus_if.load) load_cnt++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ready", 32'(bus_if.in_ready), 32'd1);
        check("midrst_busy", 32'(bus_if.busy), 32'd0);
        check("midrst_dr", {16'd0, bus_if.dr}, 32'd0);
        check("midrst_guess", {16'd0, bus_if.initial_guess}, 32'd0);
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (bus_if.load) load_cnt++;
        end
        check("midrst_no_load", 32'(load_cnt), 32'd0);

        // in_valid held high through WAIT: second pair accepted only when in_ready rises.
        first_at = -1; second_at = -1; first_dr = 16'd0; second_guess = 16'd0;
        bus_if.in_valid = 1'b1;
        bus_if.in_nr    = 16'd3072;
        bus_if.in_dr    = 16'd1024;
        @(negedge clk);
        bus_if.in_dr    = 16'd2048;
        for (int c = 1; c <= 200; c++) begin
            if (c > 1) @(negedge clk);
            if (bus_if.load) begin
                if (first_at < 0) begin
                    first_at = c;
                    first_dr = bus_if.dr;
                end else if (second_at < 0) begin
                    second_at    = c;
                    second_guess = bus_if.initial_guess;
                    break;
                end
            end
        end
        bus_if.in_valid = 1'b0;
        check("hold_first_load", 32'(first_at), 32'd8);
        check("hold_first_dr", {16'd0, first_dr}, 32'd1024);
        check("hold_second_load", 32'(second_at), 32'(8 + HOLD + 1 + 7));
        check("hold_second_guess", {16'd0, second_guess}, 32'd482);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
